act_lut_sched: RTL and testbench

ACT_LUT_SCHED -- requirements
Module: act_lut_sched

---
 rtl/act_lut_pkg.sv | 22 ++
 rtl/act_lut.sv | 27 ++
 rtl/act_lut_sched.sv | 150 +++++++++++++++
 tb/tb_act_lut_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_lut_pkg.sv
// act_lut_pkg: shared widths, LUT depth/contents and rsp_id width helper
// for the act_lut_sched activation-LUT scheduler.
package act_lut_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAC_W_DEF = 4;
  localparam int LUT_DEPTH  = 1 << (DATA_W_DEF - FRAC_W_DEF);

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lut_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Lower half ramps by 16 per entry, upper half is flat zero.
  function automatic int lut_init(input int k, input int depth);
    return (k < depth / 2) ? 16 * k : 0;
  endfunction

endpackage

// File: rtl/act_lut.sv
// act_lut: combinational activation LUT; addr in, base = lut[addr] and
// next_data = lut[addr+1] (clamped to lut[addr] at the last entry) out.
module act_lut
  import act_lut_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = DATA_W_DEF - FRAC_W_DEF
) (
  input  logic        [ADDR_W-1:0] addr,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data
);

  localparam int DEPTH = lut_depth(ADDR_W);

  logic signed [DATA_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = DATA_W'(lut_init(k, DEPTH));
  end

  always_comb begin
    base      = rom[addr];
    next_data = (&addr) ? rom[addr] : rom[addr + 1'b1];
  end

endmodule

// File: rtl/act_lut_sched.sv
// act_lut_sched: round-robin share of one activation LUT by N_REQ requesters,
// 2-stage in-order pipeline (S1 LUT/interp, S2 result). Macro: ACT_LUT_SCHED_INTERP_EN.
// Ports: clk, rst (sync high), req_valid/req_data/req_ready, rsp_valid/rsp_ready/rsp_id/rsp_data.
module act_lut_sched
  import act_lut_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_w(N_REQ)-1:0]    rsp_id,
  output logic signed [DATA_W-1:0]  rsp_data
);

  localparam int ADDR_W = DATA_W - FRAC_W;
  localparam int ID_W   = id_w(N_REQ);
  localparam int PW     = 2 * DATA_W + 1;

  localparam logic signed [PW-1:0] YMAX =
    {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] YMIN =
    {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [ID_W-1:0]          ptr;
  logic                     s1_valid;
  logic [ID_W-1:0]          s1_id;
  logic signed [DATA_W-1:0] s1_x;
  logic                     s2_valid;
  logic [ID_W-1:0]          s2_id;
  logic signed [DATA_W-1:0] s2_y;

  logic [N_REQ-1:0]         grant;
  logic [ID_W-1:0]          gidx;
  logic                     found;
  int                       idx;
  logic                     s1_adv;
  logic                     s2_adv;
  logic                     xfer;
  logic [DATA_W-1:0]        sel_data;

  // Search starts at ptr, which already holds "last grant + 1".
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = ID_W'(idx);
      end
    end
  end

  assign s2_adv    = !s2_valid || rsp_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign req_ready = (s1_adv && !rst) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign sel_data  = req_data[int'(gidx)*DATA_W +: DATA_W];

  logic [ADDR_W-1:0]        addr;
  logic [FRAC_W-1:0]        frac;
  logic signed [DATA_W-1:0] base;
  logic signed [DATA_W-1:0] next_data;
  logic signed [PW-1:0]     b_w;
  logic signed [PW-1:0]     y_w;
  logic signed [DATA_W-1:0] y_sat;

  assign addr = s1_x[DATA_W-1:FRAC_W];
  // Last entry has no successor: interpolate nothing rather than wrap.
  assign frac = (&addr) ? '0 : s1_x[FRAC_W-1:0];

  act_lut #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_lut (
    .addr      (addr),
    .base      (base),
    .next_data (next_data)
  );

  assign b_w = {{(PW-DATA_W){base[DATA_W-1]}}, base};

`ifdef ACT_LUT_SCHED_INTERP_EN
  logic signed [PW-1:0] n_w;
  logic signed [PW-1:0] f_w;
  logic signed [PW-1:0] prod;

  assign n_w  = {{(PW-DATA_W){next_data[DATA_W-1]}}, next_data};
  assign f_w  = {{(PW-FRAC_W){1'b0}}, frac};
  assign prod = (n_w - b_w) * f_w;
  assign y_w  = b_w + (prod >>> FRAC_W);
`else
  logic unused_interp;

  assign unused_interp = ^{next_data, frac};
  assign y_w           = b_w;
`endif

  always_comb begin
    if (y_w > YMAX)      y_sat = YMAX[DATA_W-1:0];
    else if (y_w < YMIN) y_sat = YMIN[DATA_W-1:0];
    else                 y_sat = y_w[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_x     <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_y     <= '0;
    end else begin
      if (xfer) begin
        ptr <= (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
      end
      if (s1_adv) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_id <= gidx;
          s1_x  <= sel_data;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id <= s1_id;
          s2_y  <= y_sat;
        end
      end
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_data  = s2_y;

endmodule

// File: tb/tb_act_lut_sched.sv
// tb_act_lut_sched: randomized + directed self-checking bench for act_lut_sched
// against a spec-level model of the LUT, interpolation and round-robin order.
module tb_act_lut_sched;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int FW    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic signed [DW-1:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    logic [7:0] d;
  } ev_t;

  ev_t hs_q[$];
  ev_t rsp_q[$];
  int  multi_hot = 0;

  always #5 clk = ~clk;

  act_lut_sched #(
    .N_REQ  (N),
    .DATA_W (DW),
    .FRAC_W (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always @(negedge clk) begin
    ev_t e;
    if (rst === 1'b0) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i;
          e.d  = req_data[i*DW +: DW];
          hs_q.push_back(e);
        end
      end
      if (rsp_valid && rsp_ready) begin
        e.id = int'(rsp_id);
        e.d  = rsp_data;
        rsp_q.push_back(e);
      end
      if ($countones(req_ready) > 1) multi_hot++;
    end
  end

  function automatic int lut(input int k);
    return (k < DEPTH / 2) ? 16 * k : 0;
  endfunction

  function automatic logic [7:0] model_y(input logic [7:0] x);
    int a, b, y;
`ifdef ACT_LUT_SCHED_INTERP_EN
    int f, n;
`endif
    a = int'(x) / (1 << FW);
    b = lut(a);
`ifdef ACT_LUT_SCHED_INTERP_EN
    f = int'(x) % (1 << FW);
    n = (a == DEPTH - 1) ? b : lut(a + 1);
    if (a == DEPTH - 1) f = 0;
    y = b + (((n - b) * f) >>> FW);
`else
    y = b;
`endif
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cmp_log(input string nm);
    n_cmp++;
    if (rsp_q.size() != hs_q.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d responses, want %0d",
               nm, rsp_q.size(), hs_q.size());
    end
    for (int i = 0; i < rsp_q.size() && i < hs_q.size(); i++) begin
      n_cmp++;
      if (rsp_q[i].id !== hs_q[i].id || rsp_q[i].d !== model_y(hs_q[i].d)) begin
        n_bad++;
        $display("FAIL %s rsp[%0d]: got id %0d data %0d, want id %0d data %0d",
                 nm, i, rsp_q[i].id, $signed(rsp_q[i].d),
                 hs_q[i].id, $signed(model_y(hs_q[i].d)));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_data = $urandom;
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset req_ready: got %b want 0000", req_ready);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset rsp_valid: got %b want 0", rsp_valid);
    end
    n_cmp++;
    if (rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset rsp_id: got %0d want 0", rsp_id);
    end
    n_cmp++;
    if (rsp_data !== 8'sd0) begin
      n_bad++;
      $display("FAIL reset rsp_data: got %0d want 0", rsp_data);
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] want;
`ifdef ACT_LUT_SCHED_INTERP_EN
    want = 8'd37;
`else
    want = 8'd32;
`endif
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data = 32'h0025_0000;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single early rsp_valid: got %b want 0", rsp_valid);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      n_bad++;
      $display("FAIL single rsp: got valid %b id %0d, want valid 1 id 2",
               rsp_valid, rsp_id);
    end
    n_cmp++;
    if (rsp_data !== want || rsp_data !== model_y(8'h25)) begin
      n_bad++;
      $display("FAIL single data: got %0d want %0d", rsp_data, want);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    hs_q.delete();
    rsp_q.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      req_data = $urandom;
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    n_cmp++;
    if (hs_q.size() != 8) begin
      n_bad++;
      $display("FAIL rr grants: got %0d want 8", hs_q.size());
    end
    for (int i = 0; i < hs_q.size(); i++) begin
      n_cmp++;
      if (hs_q[i].id != i % N) begin
        n_bad++;
        $display("FAIL rr order[%0d]: got %0d want %0d", i, hs_q[i].id, i % N);
      end
    end
    cmp_log("rr");
  endtask

  task automatic test_corners();
    logic [7:0] want7f;
`ifdef ACT_LUT_SCHED_INTERP_EN
    want7f = 8'd7;
`else
    want7f = 8'd112;
`endif
    hs_q.delete();
    rsp_q.delete();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_data = 32'h0000_00F8;
    tick();
    req_data = 32'h0000_007F;
    tick();
    req_valid = '0;
    repeat (4) tick();
    n_cmp++;
    if (rsp_q.size() != 2) begin
      n_bad++;
      $display("FAIL corner count: got %0d want 2", rsp_q.size());
    end else begin
      n_cmp++;
      if (rsp_q[0].d !== 8'd0) begin
        n_bad++;
        $display("FAIL corner f8: got %0d want 0", $signed(rsp_q[0].d));
      end
      n_cmp++;
      if (rsp_q[1].d !== want7f || rsp_q[1].id != 0) begin
        n_bad++;
        $display("FAIL corner 7f: got id %0d data %0d want id 0 data %0d",
                 rsp_q[1].id, $signed(rsp_q[1].d), want7f);
      end
    end
  endtask

  task automatic test_backpressure();
    int         accepted;
    logic [7:0] exp_d;
    do_reset();
    hs_q.delete();
    rsp_q.delete();
    rsp_ready = 1'b0;
    req_valid = '1;
    req_data = $urandom;
    exp_d = model_y(req_data[7:0]);
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      accepted += $countones(req_valid & req_ready);
      if (c >= 2) begin
        n_cmp++;
        if (req_ready !== 4'b0000) begin
          n_bad++;
          $display("FAIL bp ready cyc%0d: got %b want 0000", c, req_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp_d) begin
          n_bad++;
          $display("FAIL bp hold cyc%0d: got v%b id %0d d %0d want v1 id 0 d %0d",
                   c, rsp_valid, rsp_id, rsp_data, $signed(exp_d));
        end
      end
      tick();
    end
    n_cmp++;
    if (accepted != 2) begin
      n_bad++;
      $display("FAIL bp inflight: got %0d want 2", accepted);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();
    cmp_log("bp");
  endtask

  task automatic test_reset_midflight();
    hs_q.delete();
    rsp_q.delete();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_data = $urandom;
    tick();
    req_data = $urandom;
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (hs_q.size() != 2) begin
      n_bad++;
      $display("FAIL midrst inflight: got %0d want 2", hs_q.size());
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'sd0 ||
        req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst outputs: got v%b id %0d d %0d rdy %b want all 0",
               rsp_valid, rsp_id, rsp_data, req_ready);
    end
    rsp_ready = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (rsp_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrst stale: got %0d responses want 0", rsp_q.size());
    end
  endtask

  task automatic test_random();
    int ref_ptr;
    int pick;
    int guard;
    do_reset();
    hs_q.delete();
    rsp_q.delete();
    ref_ptr = 0;
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      req_data = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        pick = rr_pick(req_valid, ref_ptr);
        n_cmp++;
        if (pick < 0 || req_ready !== 4'(1 << pick)) begin
          n_bad++;
          $display("FAIL rand grant cyc%0d: got %b valid %b want pick %0d",
                   c, req_ready, req_valid, pick);
        end
        if (pick >= 0) ref_ptr = (pick + 1) % N;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    guard = 0;
    while (rsp_q.size() < hs_q.size() && guard < 20) begin
      tick();
      guard++;
    end
    cmp_log("rand");
    n_cmp++;
    if (multi_hot != 0) begin
      n_bad++;
      $display("FAIL onehot: got %0d multi-grant cycles want 0", multi_hot);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_corners();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
